fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of the asynchronous FIFO among `NUM_REQ` producers in the write clock domain. It grants one producer at a time, forwards that producer's data with a write strobe gated by the FIFO's `w_full`, and acknowledges each accepted word. The block sits between the producers (register-file read-out, ALU result path, control FSM) and the FIFO write-pointer/memory logic.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write bus between the producers and the write-port arbiter of the async FIFO.
// The arbiter takes the slave modport; the producer/FIFO side takes master.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data;
  logic                          w_full;
  logic [NUM_REQ-1:0]            ack;
  logic                          w_inc;
  logic [DATA_WIDTH-1:0]         w_wdata;
  logic [IDX_W-1:0]              grant_id;
  logic                          busy;

  modport master (
    output req, wr_data, w_full,
    input  ack, w_inc, w_wdata, grant_id, busy
  );

  modport slave (
    input  req, wr_data, w_full,
    output ack, w_inc, w_wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_BURST_EN for up to MAX_BURST words per grant; otherwise one word per grant.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2,
  parameter int MAX_BURST  = 4
) (
  input logic              w_clk,
  input logic              w_rst_n,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (IDX_W != $clog2(NUM_REQ))) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ must be 2..8 and IDX_W must equal clog2(NUM_REQ)");
  end
  if ((MAX_BURST < 1) || (MAX_BURST > 15)) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST must be 1..15");
  end

  state_t                  state_r;
  state_t                  state_s;
  logic [IDX_W-1:0]        grant_r;
  logic [IDX_W-1:0]        grant_s;
  logic [NUM_REQ-1:0]      sel_s;
  logic                    req_g_s;
  logic                    busy_s;
  logic                    write_s;
  logic [DATA_WIDTH-1:0]   data_s;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);
  logic [3:0]              burst_cnt_r;
  logic [3:0]              burst_cnt_s;
`endif

  // First set request strictly after 'last', wrapping at NUM_REQ-1.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (idx == LAST_IDX) ? {IDX_W{1'b0}} : (idx + IDX_W'(1));
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Route the granted producer to the FIFO port; the strobe is gated by w_full.
  always_comb begin
    sel_s  = {NUM_REQ{1'b0}};
    data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_s[i] = (grant_r == IDX_W'(i));
      data_s   = data_s | (bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_s[i]}});
    end
    busy_s  = (state_r == BURST);
    req_g_s = |(bus.req & sel_s);
    write_s = busy_s & req_g_s & ~bus.w_full;
  end

  assign bus.w_inc    = write_s;
  assign bus.ack      = sel_s & {NUM_REQ{write_s}};
  assign bus.w_wdata  = busy_s ? data_s : {DATA_WIDTH{1'b0}};
  assign bus.grant_id = grant_r;
  assign bus.busy     = busy_s;

  // Next-state logic: arbitrate in IDLE, stream words in BURST, stall while full.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
`ifdef FIFO_WR_ARB_BURST_EN
    burst_cnt_s = burst_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          grant_s = rr_pick(bus.req, grant_r);
          state_s = BURST;
`ifdef FIFO_WR_ARB_BURST_EN
          burst_cnt_s = 4'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (!req_g_s) begin
          state_s = IDLE;
        end else if (write_s) begin
`ifdef FIFO_WR_ARB_BURST_EN
          burst_cnt_s = burst_cnt_r + 4'd1;
          if (burst_cnt_r == LAST_BEAT) begin
            state_s = IDLE;
          end else begin
            state_s = BURST;
          end
`else
          state_s = IDLE;
`endif
        end else begin
          // w_full stall: hold everything, no timeout
          state_s = BURST;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, grant and burst-count registers; reset leaves producer 0 first in line.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_r <= IDLE;
      grant_r <= LAST_IDX;
`ifdef FIFO_WR_ARB_BURST_EN
      burst_cnt_r <= 4'd0;
`endif
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
`ifdef FIFO_WR_ARB_BURST_EN
      burst_cnt_r <= burst_cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table followed by multi-cycle corner sequences.
// Expectations follow FIFO_WR_ARB_BURST_EN (burst of MAX_BURST) or its absence (burst of 1).
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int MB = 4;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int EB = MB;
`else
  localparam int EB = 1;
`endif
  localparam logic [7:0] D0 = 8'hC3;
  localparam logic [7:0] D1 = 8'h5A;
  localparam logic [7:0] D2 = 8'hA5;
  localparam logic [7:0] D3 = 8'h3C;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_W(IW)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_W(IW), .MAX_BURST(MB)) dut (
    .w_clk   (clk),
    .w_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic       exp_inc;
    logic [3:0] exp_ack;
    logic [7:0] exp_data;
    logic [1:0] exp_grant;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic f, input logic inc, input logic [3:0] a,
                     input logic [7:0] d, input logic [1:0] g, input logic b);
    vec_t v;
    v.req = r; v.full = f; v.exp_inc = inc; v.exp_ack = a;
    v.exp_data = d; v.exp_grant = g; v.exp_busy = b;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    bus.req    = 4'b0000;
    bus.w_full = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.busy) ok = 1'b1;
      tick();
      if (ok) break;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pre, writes, a3, last_g, wr_total, burst_w;
    int cnt[4];
    logic done, seen, found, have_g, prev_busy, exp_inc;
    logic [1:0] exp_g;

    // Vector table: single producer bursts, then round-robin with a full stall.
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);
    add(4'b0100, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);
    for (int k = 0; k < EB; k++) add(4'b0100, 1'b0, 1'b1, 4'b0100, D2, 2'd2, 1'b1);
    add(4'b0100, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);
    add(4'b0100, 1'b0, 1'b1, 4'b0100, D2, 2'd2, 1'b1);
    if (EB > 1) add(4'b0000, 1'b0, 1'b0, 4'b0000, D2, 2'd2, 1'b1);
    else        add(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);
    add(4'b1111, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd2, 1'b0);
    for (int k = 0; k < EB; k++) add(4'b1111, 1'b0, 1'b1, 4'b1000, D3, 2'd3, 1'b1);
    add(4'b1111, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd3, 1'b0);
    for (int k = 0; k < EB; k++) add(4'b1111, 1'b0, 1'b1, 4'b0001, D0, 2'd0, 1'b1);
    add(4'b1111, 1'b1, 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    add(4'b1111, 1'b1, 1'b0, 4'b0000, D1, 2'd1, 1'b1);
    for (int k = 0; k < EB; k++) add(4'b1111, 1'b0, 1'b1, 4'b0010, D1, 2'd1, 1'b1);
    add(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0);

    rst_n       = 1'b0;
    bus.req     = 4'b0000;
    bus.w_full  = 1'b0;
    bus.wr_data = {D3, D2, D1, D0};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.req    = vecs[i].req;
      bus.w_full = vecs[i].full;
      @(negedge clk);
      chk($sformatf("vec%0d_inc", i),   bus.w_inc,    vecs[i].exp_inc);
      chk($sformatf("vec%0d_ack", i),   bus.ack,      vecs[i].exp_ack);
      chk($sformatf("vec%0d_data", i),  bus.w_wdata,  vecs[i].exp_data);
      chk($sformatf("vec%0d_grant", i), bus.grant_id, vecs[i].exp_grant);
      chk($sformatf("vec%0d_busy", i),  bus.busy,     vecs[i].exp_busy);
      tick();
    end

    // Asynchronous reset in the middle of a burst for producer 0.
    bus.req = 4'b0001;
    tick();
    #2;
    chk("rst_pre_inc", bus.w_inc, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_inc", bus.w_inc, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.w_wdata, 0);
    chk("rst_grant", bus.grant_id, 3);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rel_grant", bus.grant_id, 3);
    @(negedge clk);
    chk("rst_regrant_busy", bus.busy, 1);
    chk("rst_regrant_id", bus.grant_id, 0);
    chk("rst_regrant_ack", bus.ack, 4'b0001);
    tick();
    wait_idle("rst_idle");

    // Full stall in producer 1's burst.
    bus.req = 4'b0010;
    tick();
    pre = (EB > 1) ? 2 : 0;
    for (int k = 0; k < pre; k++) begin
      @(negedge clk);
      chk("stall_pre_ack", bus.ack, 4'b0010);
      tick();
    end
    bus.w_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_inc", bus.w_inc, 0);
      chk("stall_ack", bus.ack, 0);
      chk("stall_busy", bus.busy, 1);
      tick();
    end
    bus.w_full = 1'b0;
    writes = 0;
    done   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.busy) begin
        if (bus.w_inc) writes++;
      end else begin
        done = 1'b1;
      end
      tick();
      if (done) break;
    end
    chk("stall_done", done, 1);
    chk("stall_writes", writes, EB - pre);
    wait_idle("stall_idle");

    // Producer 3 drops its request after one word; the scan must wrap to producer 0.
    bus.req = 4'b1001;
    a3   = 0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ack[3]) a3++;
      seen = bus.busy && (bus.grant_id == 2'd3) && bus.w_inc;
      tick();
      if (seen) break;
    end
    chk("er_first_write", seen, 1);
    bus.req = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.ack[3]) a3++;
      if (bus.busy && (bus.grant_id == 2'd0)) found = 1'b1;
      tick();
      if (found) break;
    end
    chk("er_grant0", found, 1);
    chk("er_ack3_count", a3, 1);
    wait_idle("er_idle");

    // Two producers alternate, with one idle arbitration cycle between grants.
    chk("alt_start_grant", bus.grant_id, 0);
    for (int t = 0; t < 4 * (EB + 1); t++) begin
      bus.req = 4'b0011;
      exp_inc = ((t % (EB + 1)) != 0);
      exp_g   = (((t / (EB + 1)) % 2) == 0) ? 2'd1 : 2'd0;
      @(negedge clk);
      chk($sformatf("alt%0d_inc", t), bus.w_inc, exp_inc);
      if (exp_inc) begin
        chk($sformatf("alt%0d_grant", t), bus.grant_id, exp_g);
        chk($sformatf("alt%0d_ack", t), bus.ack, 4'b0001 << exp_g);
      end
      tick();
    end
    wait_idle("alt_idle");

    // Fairness with every producer requesting for 40 cycles.
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    wr_total  = 0;
    burst_w   = 0;
    last_g    = 0;
    have_g    = 1'b0;
    prev_busy = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bus.req = 4'b1111;
      @(negedge clk);
      if (bus.busy && !prev_busy) begin
        if (have_g) chk("rr_next", bus.grant_id, (last_g + 1) % 4);
        last_g  = int'(bus.grant_id);
        have_g  = 1'b1;
        burst_w = 0;
      end
      if (!bus.busy && prev_busy) chk("rr_burst_len", burst_w, EB);
      if (bus.w_inc) begin
        wr_total++;
        burst_w++;
        for (int i = 0; i < 4; i++) if (bus.ack[i]) cnt[i]++;
      end
      prev_busy = bus.busy;
      tick();
    end
    chk("rr_total", wr_total, (40 * EB) / (EB + 1));
    for (int i = 0; i < 4; i++) chk($sformatf("rr_cnt%0d", i), cnt[i], (40 * EB) / (EB + 1) / 4);
    wait_idle("rr_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
